// File: rtl/lcd_host_seq_if.sv
// Host <-> LCD controller bundle: command strobe, IROM read port, IRAM write-back and done.
// The master side is the host sequencer and the slave side is the controller.
interface lcd_host_seq_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       IROM_rd;
    logic [5:0] IROM_A;
    logic [7:0] IROM_Q;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;
    logic       done;

    modport master (
        output cmd, cmd_valid, IROM_Q,
        input  busy, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, done
    );

    modport slave (
        input  cmd, cmd_valid, IROM_Q,
        output busy, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, done
    );
endinterface

// File: rtl/lcd_host_seq.sv
// Host-side sequencer for the LCD controller: serves the source image, issues a command list
// paced by busy, captures the write-back image and reports a checksum of it.
module lcd_host_seq #(
    parameter int CMD_DEPTH = 16,
    parameter int TIMEOUT   = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd_wr_en,
    input  logic [3:0]  cmd_wr_addr,
    input  logic [3:0]  cmd_wr_data,
    input  logic [4:0]  cmd_len,
    input  logic        img_wr_en,
    input  logic [5:0]  img_wr_addr,
    input  logic [7:0]  img_wr_data,
    lcd_host_seq_if.master bus,
    input  logic [5:0]  res_rd_addr,
    output logic [7:0]  res_rd_data,
    output logic        running,
    output logic        finished,
    output logic        error,
    output logic [13:0] checksum
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_RDY, S_ISSUE, S_GAP, S_AUTO, S_COLLECT, S_SUM, S_FINISH, S_ERR
    } state_t;

    logic [3:0] cmd_mem [CMD_DEPTH];
    logic [7:0] img_mem [64];
    logic [7:0] res_mem [64];

    state_t           state_reg, state_next;
    logic [4:0]       ptr_reg, ptr_next;
    logic [4:0]       len_reg, len_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       cmd_reg, cmd_out;
    logic             cmd_valid_out;
    logic [13:0]      sum_reg, sum_next;
    logic [6:0]       sum_idx_reg, sum_idx_next;
    logic [13:0]      checksum_reg, checksum_next;
    logic [7:0]       sum_q;
    logic             idle_like, timeout_hit;

    assign idle_like   = (state_reg == S_IDLE) || (state_reg == S_FINISH) || (state_reg == S_ERR);
    assign timeout_hit = !idle_like && (state_reg != S_SUM) && (cnt_reg == CNT_W'(TIMEOUT - 1));

    // Memories are not reset; loads are accepted only while no run is in flight.
    always_ff @(posedge clk) begin
        if (idle_like && cmd_wr_en)
            cmd_mem[cmd_wr_addr] <= cmd_wr_data;
        if (idle_like && img_wr_en)
            img_mem[img_wr_addr] <= img_wr_data;
        if (state_reg == S_COLLECT && bus.IRAM_valid)
            res_mem[bus.IRAM_A] <= bus.IRAM_D;
        sum_q <= res_mem[sum_idx_reg[5:0]];
    end

    always_ff @(posedge clk) begin
        if (reset)
            res_rd_data <= 8'd0;
        else
            res_rd_data <= res_mem[res_rd_addr];
    end

    // The controller samples IROM_Q in the same cycle it presents the address.
    assign bus.IROM_Q = bus.IROM_rd ? img_mem[bus.IROM_A] : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            ptr_reg      <= 5'd0;
            len_reg      <= 5'd1;
            cnt_reg      <= '0;
            cmd_reg      <= 4'd0;
            sum_reg      <= 14'd0;
            sum_idx_reg  <= 7'd0;
            checksum_reg <= 14'd0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            len_reg      <= len_next;
            cnt_reg      <= cnt_next;
            cmd_reg      <= cmd_out;
            sum_reg      <= sum_next;
            sum_idx_reg  <= sum_idx_next;
            checksum_reg <= checksum_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        len_next      = len_reg;
        cnt_next      = cnt_reg;
        cmd_out       = cmd_reg;
        cmd_valid_out = 1'b0;
        sum_next      = sum_reg;
        sum_idx_next  = sum_idx_reg;
        checksum_next = checksum_reg;

        if (!idle_like && state_reg != S_SUM)
            cnt_next = cnt_reg + 1'b1;

        case (state_reg)
            S_IDLE, S_FINISH, S_ERR: begin
                if (start) begin
                    checksum_next = 14'd0;
                    len_next      = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
                    ptr_next      = 5'd0;
                    cnt_next      = '0;
                    state_next    = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (!bus.busy)
                    state_next = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_valid_out = 1'b1;
                cmd_out       = cmd_mem[ptr_reg[3:0]];
                if (cmd_out == 4'd0) begin
                    state_next = S_COLLECT;
                end else begin
                    ptr_next   = ptr_reg + 1'b1;
                    state_next = S_GAP;
                end
            end
            // busy only rises the cycle after a strobe, so it cannot be trusted here yet.
            S_GAP: begin
                state_next = (ptr_reg == len_reg) ? S_AUTO : S_WAIT_RDY;
            end
            S_AUTO: begin
                if (!bus.busy) begin
                    cmd_valid_out = 1'b1;
                    cmd_out       = 4'd0;
                    state_next    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.done) begin
                    sum_next     = 14'd0;
                    sum_idx_next = 7'd0;
                    state_next   = S_SUM;
                end
            end
            // Address idx is presented each cycle and its data added one cycle later.
            S_SUM: begin
                sum_idx_next = sum_idx_reg + 1'b1;
                if (sum_idx_reg != 7'd0)
                    sum_next = sum_reg + {6'd0, sum_q};
                if (sum_idx_reg == 7'd64) begin
                    checksum_next = sum_reg + {6'd0, sum_q};
                    state_next    = S_FINISH;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (timeout_hit) begin
            state_next    = S_ERR;
            cmd_valid_out = 1'b0;
            cmd_out       = cmd_reg;
        end
    end

    assign bus.cmd       = cmd_out;
    assign bus.cmd_valid = cmd_valid_out;
    assign running       = !idle_like;
    assign finished      = (state_reg == S_FINISH);
    assign error         = (state_reg == S_ERR);
    assign checksum      = checksum_reg;
endmodule

// File: tb/tb_lcd_host_seq.sv
// Directed bench for lcd_host_seq with a behavioural controller; expected commands are queued
// in a scoreboard and popped as strobes appear.
module tb_lcd_host_seq;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0;
    logic        cmd_wr_en = 1'b0;
    logic [3:0]  cmd_wr_addr = '0, cmd_wr_data = '0;
    logic [4:0]  cmd_len = 5'd1;
    logic        img_wr_en = 1'b0;
    logic [5:0]  img_wr_addr = '0;
    logic [7:0]  img_wr_data = '0;
    logic [5:0]  res_rd_addr = '0;
    logic [7:0]  res_rd_data;
    logic        running, finished, error;
    logic [13:0] checksum;

    logic       m_busy = 1'b0, busy_stuck = 1'b0;
    logic       m_rd = 1'b0, t_rd = 1'b0, m_wv = 1'b0, m_done = 1'b0;
    logic [5:0] m_a = '0, t_a = '0, m_wa = '0;
    logic [3:0] cv;
    logic       prev_valid = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] e;
    int         n_cmp = 0, n_bad = 0;
    int         n;
    int         exp_sum;

    always #5 clk = ~clk;

    lcd_host_seq_if ifc();

    assign ifc.busy       = m_busy | busy_stuck;
    assign ifc.IROM_rd    = m_rd | t_rd;
    assign ifc.IROM_A     = t_rd ? t_a : m_a;
    assign ifc.IRAM_valid = m_wv;
    assign ifc.IRAM_A     = m_wa;
    assign ifc.IRAM_D     = ifc.IROM_Q;
    assign ifc.done       = m_done;

    lcd_host_seq #(.CMD_DEPTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_wr_en(cmd_wr_en), .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
        .cmd_len(cmd_len),
        .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
        .bus(ifc),
        .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
        .running(running), .finished(finished), .error(error), .checksum(checksum)
    );

    // Controller model: non-zero commands keep busy high 3 cycles; command 0 streams the
    // whole image from IROM straight back into IRAM, raising done with the last write.
    always begin
        @(posedge clk);
        if (!reset && ifc.cmd_valid) begin
            cv = ifc.cmd;
            #1;
            m_busy = 1'b1;
            if (cv != 4'd0) begin
                repeat (3) @(posedge clk);
                #1;
            end else begin
                for (int i = 0; i < 64; i++) begin
                    if (reset) break;
                    m_rd = 1'b1; m_a = 6'(i);
                    m_wv = 1'b1; m_wa = 6'(i);
                    m_done = (i == 63);
                    @(posedge clk);
                    #1;
                end
                m_rd = 1'b0; m_wv = 1'b0; m_done = 1'b0;
            end
            m_busy = 1'b0;
        end
    end

    // Strobe monitor: scoreboard pop plus pacing rules.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (ifc.cmd_valid) begin
                n_cmp++;
                assert (ifc.busy === 1'b0) else begin
                    n_bad++; $error("FAIL strobe_busy: busy=%b required 0", ifc.busy);
                end
                n_cmp++;
                assert (prev_valid === 1'b0) else begin
                    n_bad++; $error("FAIL back_to_back: prev cmd_valid=%b required 0", prev_valid);
                end
                n_cmp++;
                assert (exp_q.size() > 0) else begin
                    n_bad++; $error("FAIL cmd_extra: got cmd=%0d, expected no strobe", ifc.cmd);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    assert (ifc.cmd === e) else begin
                        n_bad++; $error("FAIL cmd_value: got %0d expected %0d", ifc.cmd, e);
                    end
                end
            end
            prev_valid = ifc.cmd_valid;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++; $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int a, input int d);
        cmd_wr_en = 1'b1; cmd_wr_addr = 4'(a); cmd_wr_data = 4'(d);
        @(negedge clk);
        cmd_wr_en = 1'b0;
    endtask

    task automatic load_img(input bit inv);
        for (int i = 0; i < 64; i++) begin
            img_wr_en = 1'b1; img_wr_addr = 6'(i);
            img_wr_data = inv ? 8'(255 - i) : 8'(i);
            @(negedge clk);
        end
        img_wr_en = 1'b0;
        exp_sum = 0;
        for (int i = 0; i < 64; i++) exp_sum += inv ? (255 - i) : i;
    endtask

    task automatic run_start(input int len);
        cmd_len = 5'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input string tag);
        int k = 0;
        while (!finished && !error && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_finished"}, finished, 1);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_checksum"}, checksum, exp_sum);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic check_res(input bit inv);
        for (int i = 0; i < 64; i++) begin
            res_rd_addr = 6'(i);
            @(negedge clk);
            chk("res_word", res_rd_data, inv ? (255 - i) : i);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_finished"}, finished, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_checksum"}, checksum, 0);
        chk({tag, "_cmd_valid"}, ifc.cmd_valid, 0);
        chk({tag, "_cmd"}, ifc.cmd, 0);
        chk({tag, "_res_rd_data"}, res_rd_data, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Zero-latency image port.
        load_img(1'b0);
        img_wr_en = 1'b1; img_wr_addr = 6'h2A; img_wr_data = 8'h5C;
        @(negedge clk);
        img_wr_en = 1'b0;
        t_rd = 1'b1; t_a = 6'h2A;
        #1 chk("irom_hit", ifc.IROM_Q, 8'h5C);
        t_rd = 1'b0;
        #1 chk("irom_idle", ifc.IROM_Q, 0);
        load_img(1'b0);

        // Ramp image, single write command.
        set_cmd(0, 0);
        exp_q.push_back(4'd0);
        run_start(1);
        wait_finish("ramp");
        check_res(1'b0);

        // Paced list ending with an explicit write command.
        set_cmd(0, 1); set_cmd(1, 4); set_cmd(2, 5); set_cmd(3, 0);
        exp_q.push_back(4'd1); exp_q.push_back(4'd4);
        exp_q.push_back(4'd5); exp_q.push_back(4'd0);
        run_start(4);
        wait_finish("list1450");

        // No terminating zero: an automatic write command is appended.
        load_img(1'b1);
        set_cmd(0, 3); set_cmd(1, 3);
        exp_q.push_back(4'd3); exp_q.push_back(4'd3); exp_q.push_back(4'd0);
        run_start(2);
        wait_finish("list33");
        check_res(1'b1);

        // Entries after the first zero are never issued.
        set_cmd(0, 2); set_cmd(1, 0); set_cmd(2, 7);
        exp_q.push_back(4'd2); exp_q.push_back(4'd0);
        run_start(3);
        wait_finish("list207");

        // Controller never ready: timeout with no strobes.
        busy_stuck = 1'b1;
        cmd_len = 5'd1; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!error && n < 300);
        chk("timeout_cycles", n - 1, TO);
        chk("timeout_error", error, 1);
        chk("timeout_finished", finished, 0);
        chk("timeout_running", running, 0);
        chk("timeout_queue", exp_q.size(), 0);
        busy_stuck = 1'b0;
        @(negedge clk);

        // Reset in the middle of collection, then a clean rerun.
        load_img(1'b0);
        set_cmd(0, 0);
        exp_q.push_back(4'd0);
        run_start(1);
        repeat (20) @(negedge clk);
        chk("mid_collect_running", running, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        exp_q.push_back(4'd0);
        run_start(1);
        wait_finish("rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
